// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: frame constants, FSM states
// and the baud divisor helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_e;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int calc_div(input int clk, input int baud);
    return (clk + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word fall-through FIFO; the head entry is presented on data_out
// whenever valid is high. Push and pop may coincide at any occupancy.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = UART_DATA_BITS,
  parameter int DEPTH = 4
) (
  input  logic             clk_w,
  input  logic             rst_sys_w,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             valid
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_chk
    $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates full from empty when the indices match.
  assign valid    = (wr_ptr != rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop && valid;
  assign do_push  = push && (!full || do_pop);
  assign data_out = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_w or posedge rst_sys_w) begin
    if (rst_sys_w) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr[AW-1:0]] <= data_in;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling FSM and a small
// FWFT FIFO presenting received bytes on a valid/ready stream.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 25000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_w,
  input  logic       rst_sys_w,
  input  logic       rxd_i,
  output logic       rx_valid_o,
  output logic [7:0] rx_data_o,
  input  logic       rx_ready_i,
  output logic       framing_err_o,
  output logic       overrun_o,
  output logic       busy_o
);

  localparam int DIV   = calc_div(CLK_FREQ, BAUD);
  localparam int HALF  = DIV / 2;
  localparam int CNT_W = $clog2(DIV);
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  if (DIV < 4) begin : g_div_chk
    $error("uart_rx_core: CLK_FREQ/BAUD gives fewer than 4 cycles per bit");
  end

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(UART_DATA_BITS - 1);

  rx_state_e                  state, state_n;
  logic [CNT_W-1:0]           cnt, cnt_n;
  logic [BIT_W-1:0]           bit_idx, bit_n;
  logic [UART_DATA_BITS-1:0]  shreg, shreg_n;
  logic                       sync1, sync2, rx_s;
  logic [1:0]                 sync_fill;
  logic                       armed;
  logic                       push, ferr_n, ovr_n;
  logic                       fifo_full, fifo_pop;

  assign rx_s     = sync2;
  assign fifo_pop = rx_valid_o && rx_ready_i;

  // sync_fill marks when rx_s reflects the pin rather than the reset preset,
  // so a line held low out of reset never arms the receiver.
  always_ff @(posedge clk_w or posedge rst_sys_w) begin
    if (rst_sys_w) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_fill <= 2'b00;
      armed     <= 1'b0;
    end else begin
      sync1     <= rxd_i;
      sync2     <= sync1;
      sync_fill <= {sync_fill[0], 1'b1};
      if (sync_fill[1] && rx_s) armed <= 1'b1;
    end
  end

  always_ff @(posedge clk_w or posedge rst_sys_w) begin
    if (rst_sys_w) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      framing_err_o <= 1'b0;
      overrun_o     <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      bit_idx       <= bit_n;
      shreg         <= shreg_n;
      framing_err_o <= ferr_n;
      overrun_o     <= ovr_n;
      busy_o        <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    bit_n   = bit_idx;
    shreg_n = shreg;
    push    = 1'b0;
    ferr_n  = 1'b0;
    ovr_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (armed && !rx_s) begin
          state_n = START;
          cnt_n   = '0;
        end
      end
      START: begin
        if (cnt == CNT_HALF) begin
          cnt_n   = '0;
          bit_n   = '0;
          state_n = rx_s ? IDLE : DATA;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DATA: begin
        if (cnt == CNT_FULL) begin
          cnt_n   = '0;
          shreg_n = {rx_s, shreg[UART_DATA_BITS-1:1]};
          if (bit_idx == BIT_LAST) state_n = STOP;
          else                     bit_n   = bit_idx + 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      STOP: begin
        if (cnt == CNT_FULL) begin
          cnt_n = '0;
          if (!rx_s) begin
            ferr_n  = 1'b1;
            state_n = WAIT_IDLE;
          end else begin
            // A pop in the same cycle frees a slot, so only a stalled full FIFO overruns.
            push    = !fifo_full || fifo_pop;
            ovr_n   = fifo_full && !fifo_pop;
            state_n = IDLE;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      WAIT_IDLE: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_w    (clk_w),
    .rst_sys_w(rst_sys_w),
    .push     (push),
    .data_in  (shreg_n),
    .full     (fifo_full),
    .pop      (fifo_pop),
    .data_out (rx_data_o),
    .valid    (rx_valid_o)
  );

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed self-checking bench for uart_rx_core at 16 clocks per bit.
module tb_uart_rx_core;

  logic       clk_w = 1'b0;
  logic       rst_sys_w;
  logic       rxd_i;
  logic       rx_ready_i;
  logic       rx_valid_o;
  logic [7:0] rx_data_o;
  logic       framing_err_o;
  logic       overrun_o;
  logic       busy_o;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int start_cyc = 0;
  int ferr_cnt = 0;
  int ovr_cnt = 0;
  int ovr_cyc = 0;
  int vld_cnt = 0;
  int vld_cyc = 0;
  logic [7:0] vld_data = 8'h00;

  uart_rx_core #(
    .CLK_FREQ  (25000000),
    .BAUD      (1562500),
    .FIFO_DEPTH(4)
  ) dut (
    .clk_w        (clk_w),
    .rst_sys_w    (rst_sys_w),
    .rxd_i        (rxd_i),
    .rx_valid_o   (rx_valid_o),
    .rx_data_o    (rx_data_o),
    .rx_ready_i   (rx_ready_i),
    .framing_err_o(framing_err_o),
    .overrun_o    (overrun_o),
    .busy_o       (busy_o)
  );

  always #5 clk_w = ~clk_w;

  always @(posedge clk_w) cyc <= cyc + 1;

  always @(negedge clk_w) begin
    if (framing_err_o === 1'b1) ferr_cnt++;
    if (overrun_o === 1'b1) begin
      ovr_cnt++;
      ovr_cyc = cyc;
    end
    if (rx_valid_o === 1'b1) begin
      vld_cnt++;
      vld_cyc  = cyc;
      vld_data = rx_data_o;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_w);
    #1;
  endtask

  // Caller is aligned just after a rising edge; each bit lasts bt cycles.
  task automatic send_frame(input logic [7:0] b, input int bt, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    start_cyc = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd_i = f[i];
      tick(bt);
    end
  endtask

  task automatic pop_one();
    rx_ready_i = 1'b1;
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_sys_w  = 1'b1;
    rxd_i      = 1'b1;
    rx_ready_i = 1'b0;
    tick(3);
    @(negedge clk_w);
    checks += 5;
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", rx_valid_o); end
    if (rx_data_o !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", rx_data_o); end
    if (framing_err_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ferr: got %b expected 0", framing_err_o); end
    if (overrun_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_ovr: got %b expected 0", overrun_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy_o); end
    tick(1);
    rst_sys_w = 1'b0;
    tick(8);
  endtask

  task automatic test_single();
    int v0, f0, o0, lat;
    v0 = vld_cnt; f0 = ferr_cnt; o0 = ovr_cnt;
    rx_ready_i = 1'b1;
    send_frame(8'h55, 16, 1'b1);
    tick(6);
    lat = vld_cyc - start_cyc;
    checks += 5;
    if (vld_cnt - v0 != 1) begin errors++; $display("[TB] FAIL single_pulse: got %0d valid cycles expected 1", vld_cnt - v0); end
    if (vld_data !== 8'h55) begin errors++; $display("[TB] FAIL single_data: got %h expected 55", vld_data); end
    if (lat < 154 || lat > 156) begin errors++; $display("[TB] FAIL single_latency: got %0d expected 155 +-1", lat); end
    if (ferr_cnt != f0) begin errors++; $display("[TB] FAIL single_ferr: got %0d expected %0d", ferr_cnt, f0); end
    if (ovr_cnt != o0) begin errors++; $display("[TB] FAIL single_ovr: got %0d expected %0d", ovr_cnt, o0); end
    rx_ready_i = 1'b0;
    tick(4);
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_b [4];
    int f0;
    exp_b = '{8'h00, 8'hFF, 8'hA5, 8'h3C};
    f0 = ferr_cnt;
    for (int i = 0; i < 4; i++) send_frame(exp_b[i], 16, 1'b1);
    tick(5);
    @(negedge clk_w);
    checks += 2;
    if (rx_data_o !== 8'h00) begin errors++; $display("[TB] FAIL b2b_hold_a: got %h expected 00", rx_data_o); end
    if (ferr_cnt != f0) begin errors++; $display("[TB] FAIL b2b_ferr: got %0d expected %0d", ferr_cnt, f0); end
    tick(3);
    @(negedge clk_w);
    checks++;
    if (rx_data_o !== 8'h00) begin errors++; $display("[TB] FAIL b2b_hold_b: got %h expected 00", rx_data_o); end
    tick(1);
    rx_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_w);
      checks += 2;
      if (rx_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid%0d: got %b expected 1", i, rx_valid_o); end
      if (rx_data_o !== exp_b[i]) begin errors++; $display("[TB] FAIL b2b_data%0d: got %h expected %h", i, rx_data_o, exp_b[i]); end
      tick(1);
    end
    @(negedge clk_w);
    checks++;
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL b2b_empty: got %b expected 0", rx_valid_o); end
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_overrun();
    int o0, lat;
    o0 = ovr_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 16, 1'b1);
    lat = ovr_cyc - start_cyc;
    tick(5);
    checks += 2;
    if (ovr_cnt - o0 != 1) begin errors++; $display("[TB] FAIL ovr_count: got %0d expected 1", ovr_cnt - o0); end
    if (lat < 154 || lat > 156) begin errors++; $display("[TB] FAIL ovr_time: got %0d expected 155 +-1", lat); end
    rx_ready_i = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk_w);
      checks++;
      if (rx_valid_o !== 1'b1 || rx_data_o !== 8'(i)) begin
        errors++; $display("[TB] FAIL ovr_data%0d: got %b/%h expected 1/%h", i, rx_valid_o, rx_data_o, 8'(i));
      end
      tick(1);
    end
    @(negedge clk_w);
    checks++;
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL ovr_empty: got %b expected 0", rx_valid_o); end
    tick(1);
    rx_ready_i = 1'b0;
  endtask

  task automatic test_framing_break();
    int f0, idle_seen;
    f0 = ferr_cnt;
    idle_seen = 0;
    send_frame(8'h81, 16, 1'b0);
    for (int i = 0; i < 640; i++) begin
      @(negedge clk_w);
      if (busy_o !== 1'b1) idle_seen++;
      tick(1);
    end
    checks += 3;
    if (ferr_cnt - f0 != 1) begin errors++; $display("[TB] FAIL brk_ferr: got %0d expected 1", ferr_cnt - f0); end
    if (idle_seen != 0) begin errors++; $display("[TB] FAIL brk_busy: got %0d idle cycles expected 0", idle_seen); end
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL brk_nopush: got %b expected 0", rx_valid_o); end
    rxd_i = 1'b1;
    tick(6);
    @(negedge clk_w);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL brk_release: got %b expected 0", busy_o); end
    tick(10);
    send_frame(8'h42, 16, 1'b1);
    tick(5);
    @(negedge clk_w);
    checks += 2;
    if (rx_data_o !== 8'h42 || rx_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL brk_next: got %b/%h expected 1/42", rx_valid_o, rx_data_o); end
    if (ferr_cnt - f0 != 1) begin errors++; $display("[TB] FAIL brk_ferr_after: got %0d expected 1", ferr_cnt - f0); end
    tick(1);
    pop_one();
  endtask

  task automatic test_glitch_baud();
    int f0;
    f0 = ferr_cnt;
    rxd_i = 1'b0;
    tick(5);
    rxd_i = 1'b1;
    tick(30);
    @(negedge clk_w);
    checks += 3;
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_valid: got %b expected 0", rx_valid_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy: got %b expected 0", busy_o); end
    if (ferr_cnt != f0) begin errors++; $display("[TB] FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
    tick(20);
    // Bits 6 and 7 are set: at +-6% the last samples land next to them.
    send_frame(8'hC5, 15, 1'b1);
    tick(20);
    @(negedge clk_w);
    checks++;
    if (rx_data_o !== 8'hC5 || rx_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL baud15: got %b/%h expected 1/c5", rx_valid_o, rx_data_o); end
    tick(1);
    pop_one();
    tick(20);
    send_frame(8'hE7, 17, 1'b1);
    tick(20);
    @(negedge clk_w);
    checks += 2;
    if (rx_data_o !== 8'hE7 || rx_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL baud17: got %b/%h expected 1/e7", rx_valid_o, rx_data_o); end
    if (ferr_cnt != f0) begin errors++; $display("[TB] FAIL baud_ferr: got %0d expected %0d", ferr_cnt, f0); end
    tick(1);
    pop_one();
  endtask

  task automatic test_reset_midframe();
    logic [9:0] f;
    int f0, busy_seen;
    send_frame(8'h11, 16, 1'b1);
    send_frame(8'h22, 16, 1'b1);
    tick(5);
    @(negedge clk_w);
    checks++;
    if (rx_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_prefill: got %b expected 1", rx_valid_o); end
    tick(1);
    f = {1'b1, 8'h77, 1'b0};
    for (int t = 0; t < 16 * 4 + 8; t++) begin
      rxd_i = f[t / 16];
      tick(1);
    end
    #2 rst_sys_w = 1'b1;
    #1;
    checks += 2;
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_valid: got %b expected 0", rx_valid_o); end
    if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_async_busy: got %b expected 0", busy_o); end
    rxd_i = 1'b0;
    tick(3);
    rst_sys_w = 1'b0;
    f0 = ferr_cnt;
    busy_seen = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_w);
      if (busy_o !== 1'b0 || rx_valid_o !== 1'b0) busy_seen++;
      tick(1);
    end
    checks += 2;
    if (busy_seen != 0) begin errors++; $display("[TB] FAIL rst_low_ignored: got %0d active cycles expected 0", busy_seen); end
    if (ferr_cnt != f0) begin errors++; $display("[TB] FAIL rst_low_ferr: got %0d expected %0d", ferr_cnt, f0); end
    rxd_i = 1'b1;
    tick(10);
    send_frame(8'h12, 16, 1'b1);
    tick(5);
    @(negedge clk_w);
    checks++;
    if (rx_data_o !== 8'h12 || rx_valid_o !== 1'b1) begin errors++; $display("[TB] FAIL rst_next: got %b/%h expected 1/12", rx_valid_o, rx_data_o); end
    tick(1);
    pop_one();
    @(negedge clk_w);
    checks++;
    if (rx_valid_o !== 1'b0) begin errors++; $display("[TB] FAIL rst_drain: got %b expected 0", rx_valid_o); end
    tick(1);
  endtask

  initial begin
    $display("[TB] uart_rx_core directed bench");
    test_reset();
    test_single();
    test_back_to_back();
    test_overrun();
    test_framing_break();
    test_glitch_baud();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
